// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared definitions for the hazard/forwarding controller:
//   register address width, forward-select encodings and the
//   scoreboard slot record {valid, rd, load}.
package hazard_pkg;

  localparam int REG_AW = 3;
  localparam int FWD_W  = 2;

  localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXE = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              load;
  } slot_t;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// fwd_select
//   Combinational priority match of one ID source register against the
//   EX/MEM/WB scoreboard slots. The youngest producer (EX) wins.
//   Build option: R0_ZERO_EN -- register 0 never matches.
// Ports:
//   i_src      source register address
//   i_use      instruction actually reads this source
//   i_id_valid ID holds a real instruction
//   i_ex/i_mem/i_wb  scoreboard slots
//   o_sel      forward select (00 regfile, 01 EX, 10 MEM, 11 WB)
//   o_ex_load  source matches a load sitting in EX (load-use hazard)
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  logic              i_id_valid,
  input  slot_t             i_ex,
  input  slot_t             i_mem,
  input  slot_t             i_wb,
  output logic [FWD_W-1:0]  o_sel,
  output logic              o_ex_load
);

  logic w_qual;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] src);
`ifdef R0_ZERO_EN
    return s.valid && (s.rd == src) && (s.rd != '0);
`else
    return s.valid && (s.rd == src);
`endif
  endfunction

  assign w_qual    = i_use & i_id_valid;
  assign w_hit_ex  = w_qual & slot_hit(i_ex,  i_src);
  assign w_hit_mem = w_qual & slot_hit(i_mem, i_src);
  assign w_hit_wb  = w_qual & slot_hit(i_wb,  i_src);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_ex)       o_sel = FWD_EXE;
    else if (w_hit_mem) o_sel = FWD_MEM;
    else if (w_hit_wb)  o_sel = FWD_WB;
  end

  assign o_ex_load = w_hit_ex & i_ex.load;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Hazard controller for the 16-bit five-stage pipeline. Tracks the
//   destination registers of the EX/MEM/WB instructions, drives the ID
//   forwarding selects, inserts load-use stalls, flushes IF/ID on
//   redirects resolved in ID and freezes everything while data memory
//   is busy. All outputs are combinational from the slots and inputs.
//   Build option: R0_ZERO_EN -- register 0 is hardwired zero.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid/ra/rb/use_a/use_b ID instruction sources
//   id_rd/id_wr/id_load        ID instruction destination info
//   id_redirect                taken branch/jump in ID
//   mem_busy                   data memory stall
//   forward_a/forward_b        ID forward mux selects
//   pc_hold/ifid_hold          PC and IF/ID write disables
//   ifid_flush/idex_bubble     bubble injection controls
//   pipe_freeze                whole-pipeline hold
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = hazard_pkg::REG_AW,
  parameter int FWD_W  = hazard_pkg::FWD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_redirect,
  input  logic              mem_busy,
  output logic [FWD_W-1:0]  forward_a,
  output logic [FWD_W-1:0]  forward_b,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze
);

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  logic w_lu_a;
  logic w_lu_b;
  logic w_load_use;
  logic w_ex_valid;

  fwd_select u_fwd_a (
    .i_src      (id_ra),
    .i_use      (id_use_a),
    .i_id_valid (id_valid),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (forward_a),
    .o_ex_load  (w_lu_a)
  );

  fwd_select u_fwd_b (
    .i_src      (id_rb),
    .i_use      (id_use_b),
    .i_id_valid (id_valid),
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .o_sel      (forward_b),
    .o_ex_load  (w_lu_b)
  );

  assign w_load_use = w_lu_a | w_lu_b;

  // A memory freeze overrides the load-use stall; the stall is simply
  // re-evaluated from the held slots once the freeze drops.
  assign pipe_freeze = mem_busy;
  assign pc_hold     = mem_busy | w_load_use;
  assign ifid_hold   = mem_busy | w_load_use;
  assign idex_bubble = ~mem_busy & w_load_use;
  // Redirect waits while its operands are not ready.
  assign ifid_flush  = ~mem_busy & id_valid & id_redirect & ~w_load_use;

`ifdef R0_ZERO_EN
  assign w_ex_valid = id_valid & id_wr & ~w_load_use & (id_rd != '0);
`else
  assign w_ex_valid = id_valid & id_wr & ~w_load_use;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (!mem_busy) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= '{valid: w_ex_valid, rd: id_rd, load: id_load};
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

`ifdef R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_ra = '0, id_rb = '0, id_rd = '0;
  logic       id_use_a = 1'b0, id_use_b = 1'b0;
  logic       id_wr = 1'b0, id_load = 1'b0, id_redirect = 1'b0, mem_busy = 1'b0;
  logic [1:0] forward_a, forward_b;
  logic       pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_redirect(id_redirect), .mem_busy(mem_busy),
    .forward_a(forward_a), .forward_b(forward_b), .pc_hold(pc_hold),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze)
  );

  // Packed result: {fa[1:0], fb[1:0], pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}
  typedef struct {
    logic       v;
    logic [2:0] ra, rb;
    logic       ua, ub;
    logic [2:0] rd;
    logic       wr, ld, rdr, busy;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] ra, logic [2:0] rb, logic ua, logic ub,
                              logic [2:0] rd, logic wr, logic ld, logic rdr, logic busy,
                              logic [8:0] exp);
    vec_t t;
    t.v = v; t.ra = ra; t.rb = rb; t.ua = ua; t.ub = ub; t.rd = rd;
    t.wr = wr; t.ld = ld; t.rdr = rdr; t.busy = busy; t.exp = exp;
    return t;
  endfunction

  task automatic drive(vec_t t);
    id_valid = t.v; id_ra = t.ra; id_rb = t.rb; id_use_a = t.ua; id_use_b = t.ub;
    id_rd = t.rd; id_wr = t.wr; id_load = t.ld; id_redirect = t.rdr; mem_busy = t.busy;
  endtask

  function automatic logic [8:0] outs();
    return {forward_a, forward_b, pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze};
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got fa=%b fb=%b hold=%b%b flush=%b bub=%b frz=%b, expected fa=%b fb=%b hold=%b%b flush=%b bub=%b frz=%b",
               name, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
               exp[8:7], exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: in-flight producers indexed by age (0 = one ahead of ID).
  bit       h_v[3];
  bit [2:0] h_rd[3];
  bit       h_ld[3];

  function automatic bit hit(int age, logic [2:0] src);
    return h_v[age] && (h_rd[age] == src) && !(R0Z && src == 3'd0);
  endfunction

  function automatic logic [1:0] model_sel(logic v, logic use_s, logic [2:0] src);
    logic [1:0] s;
    s = 2'd0;
    if (v && use_s)
      for (int age = 2; age >= 0; age--)
        if (hit(age, src)) s = 2'(age + 1);
    return s;
  endfunction

  vec_t nop;

  initial begin
    logic [8:0] e;
    logic       lu;
    vec_t       r;
    vec_t       rs;

    nop = mk(0,0,0,0,0,0,0,0,0,0, 9'b0);

    // Directed cycle-by-cycle sequences
    tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 9'b00_00_00000)); // ADD R3
    tbl.push_back(mk(1,3,1,1,1,4,1,0,0,0, 9'b01_00_00000)); // R3 in EX
    tbl.push_back(mk(1,3,6,1,1,5,1,0,0,0, 9'b10_00_00000)); // R3 in MEM
    tbl.push_back(mk(1,3,6,1,1,6,1,0,0,0, 9'b11_00_00000)); // R3 in WB
    tbl.push_back(mk(1,3,1,1,0,7,1,0,0,0, 9'b00_00_00000)); // R3 retired
    repeat (3) tbl.push_back(nop);
    tbl.push_back(mk(1,1,1,1,0,2,1,1,0,0, 9'b00_00_00000)); // LW R2
    tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 9'b00_01_11010)); // load-use stall
    tbl.push_back(mk(1,1,2,1,1,3,1,0,0,0, 9'b00_10_00000)); // released, MEM fwd
    tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0, 9'b00_00_00000)); // ADD R5
    tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0, 9'b00_00_00000)); // ADD R6
    tbl.push_back(mk(1,0,0,0,0,5,1,0,0,0, 9'b00_00_00000)); // ADD R5
    tbl.push_back(mk(1,5,0,1,0,1,0,0,0,0, 9'b01_00_00000)); // EX beats WB
    repeat (3) tbl.push_back(nop);
    tbl.push_back(mk(1,1,2,1,1,0,0,0,1,0, 9'b00_00_00100)); // taken BEQ
    tbl.push_back(nop);
    tbl.push_back(mk(1,2,3,1,0,1,1,1,0,0, 9'b00_00_00000)); // LW R1
    tbl.push_back(mk(1,1,2,1,1,0,0,0,1,0, 9'b01_00_11010)); // BEQ R1: stall, no flush
    tbl.push_back(mk(1,1,2,1,1,0,0,0,1,0, 9'b10_00_00100)); // BEQ re-evaluated
    repeat (3) tbl.push_back(nop);
    tbl.push_back(mk(1,1,2,0,0,4,1,0,0,0, 9'b00_00_00000)); // ADD R4
    tbl.push_back(mk(1,0,0,0,0,6,1,0,0,0, 9'b00_00_00000)); // ADD R6
    repeat (3) tbl.push_back(mk(1,4,0,1,0,7,1,0,0,1, 9'b10_00_11001)); // mem_busy
    tbl.push_back(mk(1,4,0,1,0,7,0,0,0,0, 9'b10_00_00000)); // slots held
    tbl.push_back(mk(1,4,0,1,0,7,0,0,0,0, 9'b11_00_00000)); // advanced once
    tbl.push_back(mk(1,1,1,0,0,3,1,1,0,0, 9'b00_00_00000)); // LW R3
    tbl.push_back(mk(1,3,0,1,0,2,1,0,0,1, 9'b01_00_11001)); // busy + load-use: freeze wins
    tbl.push_back(mk(1,3,0,1,0,2,1,0,0,0, 9'b01_00_11010)); // stall after release
    tbl.push_back(mk(1,3,0,1,0,2,1,0,0,0, 9'b10_00_00000));

    // Reset state
    #1 check("reset", outs(), 9'b0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1 check($sformatf("row%0d", i), outs(), tbl[i].exp);
    end

    // Reset asserted during a load-use stall
    @(negedge clk) drive(nop);
    @(negedge clk) drive(nop);
    @(negedge clk) drive(nop);
    @(negedge clk) drive(mk(1,1,1,0,0,2,1,1,0,0, 9'b0));
    rs = mk(1,1,2,1,1,3,1,0,0,0, 9'b00_01_11010);
    @(negedge clk) drive(rs);
    #1 check("rst_pre_stall", outs(), rs.exp);
    rst_n = 1'b0;
    #1 check("rst_mid_stall", outs(), 9'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rst_released", outs(), 9'b0);
    @(negedge clk) drive(rs);
    #1 check("rst_no_stall", outs(), 9'b0);

    // R0 behaviour
    repeat (3) @(negedge clk) drive(nop);
    @(negedge clk) drive(mk(1,1,1,0,0,0,1,0,0,0, 9'b0)); // ADD R0
    @(negedge clk) drive(mk(1,0,1,1,0,2,0,0,0,0, 9'b0));
    #1 check("r0_read", outs(), R0Z ? 9'b00_00_00000 : 9'b01_00_00000);

    // Randomized run against the age-based model
    @(negedge clk) rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin h_v[k] = 0; h_rd[k] = 0; h_ld[k] = 0; end
    @(negedge clk) rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r.v    = ($urandom_range(0, 7) != 0);
      r.ra   = 3'($urandom_range(0, 3));
      r.rb   = 3'($urandom_range(0, 3));
      r.ua   = 1'($urandom);
      r.ub   = 1'($urandom);
      r.rd   = 3'($urandom_range(0, 3));
      r.wr   = ($urandom_range(0, 3) != 0);
      r.ld   = ($urandom_range(0, 2) == 0);
      r.rdr  = ($urandom_range(0, 4) == 0);
      r.busy = ($urandom_range(0, 4) == 0);
      drive(r);
      lu = r.v && ((r.ua && hit(0, r.ra) && h_ld[0]) || (r.ub && hit(0, r.rb) && h_ld[0]));
      e[8:7] = model_sel(r.v, r.ua, r.ra);
      e[6:5] = model_sel(r.v, r.ub, r.rb);
      e[4]   = r.busy || lu;
      e[3]   = r.busy || lu;
      e[2]   = !r.busy && r.v && r.rdr && !lu;
      e[1]   = !r.busy && lu;
      e[0]   = r.busy;
      #1 check($sformatf("rand%0d", n), outs(), e);
      if (!r.busy) begin
        for (int k = 2; k > 0; k--) begin
          h_v[k] = h_v[k-1]; h_rd[k] = h_rd[k-1]; h_ld[k] = h_ld[k-1];
        end
        h_v[0]  = r.v && r.wr && !lu && !(R0Z && r.rd == 3'd0);
        h_rd[0] = r.rd;
        h_ld[0] = r.ld;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
